// File: rtl/ja_note_receiver.sv
// Receives note words from the JA PMOD and assembles them into the per-frame note vector.
// Optional: define JA_PARITY_CHECK_EN to reject words whose synced byte has even parity.
module ja_note_receiver #(
   parameter int unsigned NOTES         = 37,
   parameter int unsigned FRAME_TIMEOUT = 100000,
   parameter int unsigned STALE_CYCLES  = 5000000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [7:0]       ja_in,
   output logic [NOTES-1:0] ndata,
   output logic             ndata_valid,
   output logic             frame_err,
   output logic [7:0]       err_count,
   output logic             link_up
);

   localparam int unsigned FW = (FRAME_TIMEOUT > 1) ? $clog2(FRAME_TIMEOUT) : 1;
   localparam int unsigned SW = (STALE_CYCLES > 1) ? $clog2(STALE_CYCLES) : 1;
   localparam logic [5:0] CodeSof = 6'd62;
   localparam logic [5:0] CodeEof = 6'd63;

   typedef enum logic [0:0] {StIdle, StCollect} state_t;

   logic [7:0]       r_sync1;
   logic [7:0]       r_sync2;
   logic             r_prev_strobe;
   logic             r_word_vld;
   logic             r_par_ok;
   logic [5:0]       r_code;
   state_t           r_state;
   logic [NOTES-1:0] r_acc;
   logic [FW-1:0]    r_frame_tmr;
   logic [SW-1:0]    r_stale_tmr;

   logic             w_par_ok;
   logic             w_timeout;
   logic             w_stale_exp;
   logic             w_evt;
   logic             w_is_note;
   logic             w_is_sof;
   logic             w_is_eof;
   logic             w_err;
   logic             w_publish;
   logic [NOTES-1:0] w_note_mask;

`ifdef JA_PARITY_CHECK_EN
   assign w_par_ok = ^r_sync2;
`else
   logic w_unused_par;
   assign w_unused_par = r_sync2[7];
   assign w_par_ok     = 1'b1;
`endif

   // Word is registered once after edge detection so EOF reaches ndata on the 4th edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1       <= 8'd0;
         r_sync2       <= 8'd0;
         r_prev_strobe <= 1'b0;
         r_word_vld    <= 1'b0;
         r_code        <= 6'd0;
         r_par_ok      <= 1'b0;
      end else begin
         r_sync1       <= ja_in;
         r_sync2       <= r_sync1;
         r_prev_strobe <= r_sync2[6];
         r_word_vld    <= r_sync2[6] ^ r_prev_strobe;
         r_code        <= r_sync2[5:0];
         r_par_ok      <= w_par_ok;
      end
   end

   assign w_timeout   = (r_state == StCollect) && (r_frame_tmr == FW'(FRAME_TIMEOUT - 1));
   assign w_stale_exp = (r_stale_tmr == SW'(STALE_CYCLES - 1));
   assign w_evt       = r_word_vld && !w_timeout && r_par_ok;
   assign w_is_note   = 32'(r_code) < NOTES;
   assign w_is_sof    = (r_code == CodeSof);
   assign w_is_eof    = (r_code == CodeEof);
   assign w_note_mask = NOTES'(1) << r_code;
   // Inside a frame anything that is neither a note nor EOF (illegal or SOF) is an error.
   assign w_err       = w_timeout || (r_word_vld && !w_timeout && !r_par_ok) ||
                        (w_evt && (r_state == StCollect) && !w_is_note && !w_is_eof);
   assign w_publish   = w_evt && (r_state == StCollect) && w_is_eof;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= StIdle;
         r_acc       <= '0;
         r_frame_tmr <= '0;
         r_stale_tmr <= '0;
         ndata       <= '0;
         ndata_valid <= 1'b0;
         frame_err   <= 1'b0;
         err_count   <= 8'd0;
         link_up     <= 1'b0;
      end else begin
         frame_err   <= w_err;
         ndata_valid <= w_publish;
         if (w_err && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
         end

         if (w_publish) begin
            ndata       <= r_acc;
            link_up     <= 1'b1;
            r_stale_tmr <= '0;
         end else if (w_stale_exp) begin
            ndata   <= '0;
            link_up <= 1'b0;
         end else begin
            r_stale_tmr <= r_stale_tmr + 1'b1;
         end

         unique case (r_state)
            StIdle: begin
               if (w_evt && w_is_sof) begin
                  r_state     <= StCollect;
                  r_acc       <= '0;
                  r_frame_tmr <= '0;
               end
            end
            StCollect: begin
               if (w_timeout) begin
                  r_state <= StIdle;
               end else begin
                  r_frame_tmr <= r_frame_tmr + 1'b1;
                  if (w_evt) begin
                     if (w_is_sof) begin
                        r_acc       <= '0;
                        r_frame_tmr <= '0;
                     end else if (w_is_eof) begin
                        r_state <= StIdle;
                     end else if (w_is_note) begin
                        r_acc <= r_acc | w_note_mask;
                     end
                  end
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_ja_note_receiver.sv
// Bench for ja_note_receiver: word-level reference model with randomized frames.
module tb_ja_note_receiver;

   localparam int unsigned NOTES      = 37;
   localparam int unsigned TB_TIMEOUT = 200;
   localparam int unsigned TB_STALE   = 6000;
   localparam logic [5:0]  SOF        = 6'd62;
   localparam logic [5:0]  EOF        = 6'd63;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [7:0]       ja_in;
   logic [NOTES-1:0] ndata;
   logic             ndata_valid;
   logic             frame_err;
   logic [7:0]       err_count;
   logic             link_up;

   int vectors     = 0;
   int miscompares = 0;
   int n_valid     = 0;
   int n_err       = 0;

   // Reference model state, kept at the level of words and frames.
   bit m_busy;
   bit m_seen[NOTES];
   bit m_pub[NOTES];
   bit m_link;
   int m_err_reg;
   int m_err_pulses;
   int m_valid;

   always #5 clk = ~clk;

   ja_note_receiver #(
      .NOTES        (NOTES),
      .FRAME_TIMEOUT(TB_TIMEOUT),
      .STALE_CYCLES (TB_STALE)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ja_in      (ja_in),
      .ndata      (ndata),
      .ndata_valid(ndata_valid),
      .frame_err  (frame_err),
      .err_count  (err_count),
      .link_up    (link_up)
   );

   always @(negedge clk) begin
      if (ndata_valid === 1'b1) n_valid++;
      if (frame_err === 1'b1) n_err++;
   end

   function automatic logic [NOTES-1:0] exp_ndata();
      logic [NOTES-1:0] v = '0;
      for (int n = 0; n < NOTES; n++) if (m_pub[n]) v[n] = 1'b1;
      return v;
   endfunction

   function automatic logic [7:0] exp_errcnt();
      return (m_err_reg > 255) ? 8'd255 : 8'(m_err_reg);
   endfunction

   function automatic void model_err();
      m_err_reg++;
      m_err_pulses++;
   endfunction

   function automatic void model_word(input int code, input bit rejected);
      if (rejected) begin
         model_err();
         return;
      end
      if (!m_busy) begin
         if (code == 62) begin
            m_busy = 1'b1;
            foreach (m_seen[n]) m_seen[n] = 1'b0;
         end
      end else if (code < NOTES) begin
         m_seen[code] = 1'b1;
      end else if (code == 62) begin
         model_err();
         foreach (m_seen[n]) m_seen[n] = 1'b0;
      end else if (code == 63) begin
         m_pub   = m_seen;
         m_link  = 1'b1;
         m_busy  = 1'b0;
         m_valid++;
      end else begin
         model_err();
      end
   endfunction

   task automatic do_reset();
      reset_n = 1'b0;
      ja_in   = 8'd0;
      repeat (3) @(negedge clk);
      m_busy    = 1'b0;
      m_link    = 1'b0;
      m_err_reg = 0;
      foreach (m_seen[n]) m_seen[n] = 1'b0;
      foreach (m_pub[n]) m_pub[n] = 1'b0;
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   // Code settles 4 clocks before the strobe toggles and is held 5 clocks after it.
   task automatic send_word(input logic [5:0] code, input bit bad, input bit lat);
      logic s;
      logic p;
      @(negedge clk);
      ja_in[5:0] = code;
      ja_in[7]   = ~^{ja_in[6], code};
      repeat (4) @(negedge clk);
      s = ~ja_in[6];
      p = ~^{s, code};
      if (bad) p = ~p;
      ja_in = {p, s, code};
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         if (lat) begin
            vectors++;
            if (ndata_valid !== 1'(i == 4)) begin
               miscompares++;
               $display("FAIL eof_latency edge %0d: got %b want %b", i, ndata_valid, (i == 4));
            end
         end
      end
`ifdef JA_PARITY_CHECK_EN
      model_word(int'(code), bad);
`else
      model_word(int'(code), 1'b0);
`endif
   endtask

   task automatic test_reset();
      do_reset();
      vectors += 5;
      if (ndata !== '0) begin
         miscompares++; $display("FAIL reset_ndata: got %h want 0", ndata);
      end
      if (ndata_valid !== 1'b0) begin
         miscompares++; $display("FAIL reset_valid: got %b want 0", ndata_valid);
      end
      if (frame_err !== 1'b0) begin
         miscompares++; $display("FAIL reset_err: got %b want 0", frame_err);
      end
      if (err_count !== 8'd0) begin
         miscompares++; $display("FAIL reset_errcnt: got %0d want 0", err_count);
      end
      if (link_up !== 1'b0) begin
         miscompares++; $display("FAIL reset_link: got %b want 0", link_up);
      end
   endtask

   task automatic test_basic();
      logic [NOTES-1:0] want = '0;
      want[0] = 1'b1; want[5] = 1'b1; want[36] = 1'b1;
      send_word(SOF, 1'b0, 1'b0);
      send_word(6'd0, 1'b0, 1'b0);
      send_word(6'd5, 1'b0, 1'b0);
      send_word(6'd36, 1'b0, 1'b0);
      send_word(EOF, 1'b0, 1'b1);
      vectors += 4;
      if (ndata !== want) begin
         miscompares++; $display("FAIL basic_ndata: got %h want %h", ndata, want);
      end
      if (link_up !== 1'b1) begin
         miscompares++; $display("FAIL basic_link: got %b want 1", link_up);
      end
      if (err_count !== 8'd0) begin
         miscompares++; $display("FAIL basic_errcnt: got %0d want 0", err_count);
      end
      if (n_valid !== m_valid) begin
         miscompares++; $display("FAIL basic_pulses: got %0d want %0d", n_valid, m_valid);
      end
   endtask

   task automatic test_restart();
      send_word(SOF, 1'b0, 1'b0);
      send_word(6'd3, 1'b0, 1'b0);
      send_word(SOF, 1'b0, 1'b0);
      send_word(6'd7, 1'b0, 1'b0);
      send_word(EOF, 1'b0, 1'b0);
      vectors += 3;
      if (ndata !== exp_ndata()) begin
         miscompares++; $display("FAIL restart_ndata: got %h want %h", ndata, exp_ndata());
      end
      if (n_err !== m_err_pulses) begin
         miscompares++; $display("FAIL restart_pulses: got %0d want %0d", n_err, m_err_pulses);
      end
      if (err_count !== exp_errcnt()) begin
         miscompares++; $display("FAIL restart_errcnt: got %0d want %0d", err_count, exp_errcnt());
      end
   endtask

   task automatic test_timeout();
      send_word(SOF, 1'b0, 1'b0);
      send_word(6'd2, 1'b0, 1'b0);
      repeat (TB_TIMEOUT + 20) @(negedge clk);
      if (m_busy) begin
         model_err();
         m_busy = 1'b0;
      end
      vectors += 3;
      if (n_err !== m_err_pulses) begin
         miscompares++; $display("FAIL timeout_pulses: got %0d want %0d", n_err, m_err_pulses);
      end
      if (err_count !== exp_errcnt()) begin
         miscompares++; $display("FAIL timeout_errcnt: got %0d want %0d", err_count, exp_errcnt());
      end
      if (ndata !== exp_ndata()) begin
         miscompares++; $display("FAIL timeout_ndata: got %h want %h", ndata, exp_ndata());
      end
      send_word(EOF, 1'b0, 1'b0);
      vectors += 2;
      if (n_valid !== m_valid) begin
         miscompares++; $display("FAIL timeout_late_eof: got %0d want %0d", n_valid, m_valid);
      end
      if (ndata !== exp_ndata()) begin
         miscompares++; $display("FAIL timeout_ndata2: got %h want %h", ndata, exp_ndata());
      end
   endtask

   task automatic test_parity();
      send_word(SOF, 1'b0, 1'b0);
      send_word(6'd4, 1'b1, 1'b0);
      send_word(EOF, 1'b0, 1'b0);
      vectors += 3;
`ifdef JA_PARITY_CHECK_EN
      if (ndata[4] !== 1'b0) begin
         miscompares++; $display("FAIL parity_bit4: got %b want 0", ndata[4]);
      end
`else
      if (ndata[4] !== 1'b1) begin
         miscompares++; $display("FAIL parity_bit4: got %b want 1", ndata[4]);
      end
`endif
      if (err_count !== exp_errcnt()) begin
         miscompares++; $display("FAIL parity_errcnt: got %0d want %0d", err_count, exp_errcnt());
      end
      if (n_err !== m_err_pulses) begin
         miscompares++; $display("FAIL parity_pulses: got %0d want %0d", n_err, m_err_pulses);
      end
   endtask

   task automatic test_random();
      for (int f = 0; f < 20; f++) begin
         if ($urandom_range(0, 3) == 0) send_word(6'($urandom_range(0, 63)), 1'b0, 1'b0);
         send_word(SOF, 1'b0, 1'b0);
         for (int w = $urandom_range(0, 8); w > 0; w--) begin
            case ($urandom_range(0, 9))
               6:       send_word(6'($urandom_range(NOTES, 61)), 1'b0, 1'b0);
               7:       send_word(SOF, 1'b0, 1'b0);
               8:       send_word(6'($urandom_range(0, NOTES - 1)), 1'b1, 1'b0);
               default: send_word(6'($urandom_range(0, NOTES - 1)), 1'b0, 1'b0);
            endcase
         end
         send_word(EOF, 1'b0, 1'b0);
         vectors += 4;
         if (ndata !== exp_ndata()) begin
            miscompares++; $display("FAIL rand%0d_ndata: got %h want %h", f, ndata, exp_ndata());
         end
         if (err_count !== exp_errcnt()) begin
            miscompares++;
            $display("FAIL rand%0d_errcnt: got %0d want %0d", f, err_count, exp_errcnt());
         end
         if (n_valid !== m_valid) begin
            miscompares++; $display("FAIL rand%0d_valid: got %0d want %0d", f, n_valid, m_valid);
         end
         if (n_err !== m_err_pulses) begin
            miscompares++;
            $display("FAIL rand%0d_errp: got %0d want %0d", f, n_err, m_err_pulses);
         end
      end
   endtask

   task automatic test_saturation();
      do_reset();
      send_word(SOF, 1'b0, 1'b0);
      send_word(6'd40, 1'b0, 1'b0);
      vectors++;
      if (err_count !== 8'd1) begin
         miscompares++; $display("FAIL sat_first: got %0d want 1", err_count);
      end
      // Repeated SOF keeps restarting the frame timer, so only the SOFs count as errors.
      for (int i = 0; i < 300; i++) send_word(SOF, 1'b0, 1'b0);
      vectors += 2;
      if (err_count !== 8'd255) begin
         miscompares++; $display("FAIL sat_cap: got %0d want 255", err_count);
      end
      if (n_err !== m_err_pulses) begin
         miscompares++; $display("FAIL sat_pulses: got %0d want %0d", n_err, m_err_pulses);
      end
      send_word(EOF, 1'b0, 1'b0);
      vectors++;
      if (err_count !== 8'd255) begin
         miscompares++; $display("FAIL sat_hold: got %0d want 255", err_count);
      end
   endtask

   task automatic test_stale();
      send_word(SOF, 1'b0, 1'b0);
      send_word(6'd11, 1'b0, 1'b0);
      send_word(EOF, 1'b0, 1'b0);
      repeat (TB_STALE - 100) @(negedge clk);
      vectors += 2;
      if (link_up !== 1'b1) begin
         miscompares++; $display("FAIL stale_early_link: got %b want 1", link_up);
      end
      if (ndata !== exp_ndata()) begin
         miscompares++; $display("FAIL stale_early_ndata: got %h want %h", ndata, exp_ndata());
      end
      repeat (200) @(negedge clk);
      m_link = 1'b0;
      foreach (m_pub[n]) m_pub[n] = 1'b0;
      vectors += 3;
      if (ndata !== exp_ndata()) begin
         miscompares++; $display("FAIL stale_ndata: got %h want %h", ndata, exp_ndata());
      end
      if (link_up !== 1'b0) begin
         miscompares++; $display("FAIL stale_link: got %b want 0", link_up);
      end
      if (n_valid !== m_valid) begin
         miscompares++; $display("FAIL stale_valid: got %0d want %0d", n_valid, m_valid);
      end
   endtask

   task automatic test_reset_midframe();
      send_word(SOF, 1'b0, 1'b0);
      send_word(6'd9, 1'b0, 1'b0);
      do_reset();
      vectors += 2;
      if (err_count !== 8'd0) begin
         miscompares++; $display("FAIL midreset_errcnt: got %0d want 0", err_count);
      end
      if (link_up !== 1'b0) begin
         miscompares++; $display("FAIL midreset_link: got %b want 0", link_up);
      end
      send_word(EOF, 1'b0, 1'b0);
      send_word(SOF, 1'b0, 1'b0);
      send_word(EOF, 1'b0, 1'b0);
      vectors += 2;
      if (ndata !== exp_ndata()) begin
         miscompares++; $display("FAIL midreset_ndata: got %h want %h", ndata, exp_ndata());
      end
      if (n_valid !== m_valid) begin
         miscompares++; $display("FAIL midreset_valid: got %0d want %0d", n_valid, m_valid);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      ja_in   = 8'd0;
      test_reset();
      test_basic();
      test_restart();
      test_timeout();
      test_parity();
      test_random();
      test_saturation();
      test_stale();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/ja_note_receiver.md
Name: ja_note_receiver

Overview:
- Upstream of the score-computation stage: receives detected-note events from the external FFT board over the JA PMOD and assembles them into the 37-bit per-frame note vector (NDATA) that score computation consumes.
- Replaces the free-running test pattern generator currently driving NDATA.
- Handles clock-domain crossing, frame assembly, timeout, staleness and error accounting.

Parameters:
- NOTES, 37, width of the note vector; codes 0..NOTES-1 are valid notes.
- FRAME_TIMEOUT, 100000, max cycles between SOF and EOF before the frame is dropped.
- STALE_CYCLES, 5000000, cycles without a published frame before ndata is cleared and link_up drops.

Ports:
- clk  input  1  system clock (100 MHz domain).
- reset_n  input  1  asynchronous active-low reset.
- ja_in  input  8  raw PMOD pins: [5:0] code, [6] toggle strobe, [7] odd parity over [6:0].
- ndata  output  NOTES  last published note vector; bit n = note n detected.
- ndata_valid  output  1  one-cycle pulse when ndata is updated by a publish.
- frame_err  output  1  one-cycle pulse per protocol error.
- err_count  output  8  saturating error counter.
- link_up  output  1  high while frames arrive within STALE_CYCLES.

Behaviour:
- Reset (async, reset_n=0): ndata=0, ndata_valid=0, frame_err=0, err_count=0, link_up=0, FSM=IDLE, accumulator=0, both timers=0, synchronizers cleared.
- All 8 ja_in bits pass through a 2-flop synchronizer. A word event fires when synced bit 6 differs from its registered previous value; code and parity are sampled from the synced bus in that cycle.
- Sender guarantees code bits are stable at least 4 clk before and after each toggle.
- Code map: 0..36 = note; 62 = SOF; 63 = EOF; 37..61 = illegal.
- FSM IDLE:
  - SOF -> COLLECT; accumulator cleared; frame timer cleared.
  - Note, EOF and illegal codes are ignored silently.
- FSM COLLECT:
  - Note n: accumulator[n] <= 1. A repeated note is idempotent.
  - Illegal code: error; stay in COLLECT.
  - SOF: error; accumulator cleared; frame timer cleared; stay in COLLECT (restart).
  - EOF: publish -> ndata <= accumulator; ndata_valid=1 for one cycle; link_up <= 1; stale timer cleared; -> IDLE.
  - Frame timer reaching FRAME_TIMEOUT-1 with no EOF: error; -> IDLE; ndata unchanged.
- Frame timer counts every cycle in COLLECT only.
- Error: frame_err=1 for one cycle; err_count += 1, saturating at 255 (no wrap).
- Stale timer counts every cycle and clears on publish. On reaching STALE_CYCLES-1: ndata <= 0, link_up <= 0, no ndata_valid pulse; timer holds until the next publish.
- Latency: the pin toggle carrying EOF to ndata/ndata_valid is 4 clk edges (2 sync, 1 edge-detect, 1 output register).
- Simultaneous cases:
  - Timeout and a word event in the same cycle: timeout wins; the word is discarded.
  - Publish and stale expiry in the same cycle: publish wins.
- Reset mid-frame discards the partial accumulator. The first toggle after reset is measured against the reset value 0 of the previous-strobe register.

Optional Feature:
- Macro JA_PARITY_CHECK_EN.
- Defined: each word event checks that ja_in[7:0] (synced) has odd overall parity. A mismatch counts as an error (frame_err, err_count), the word is discarded, and FSM state is unchanged.
- Undefined: bit 7 is ignored; all words are accepted.

Test Plan:
- Reset, then SOF, notes 0, 5, 36, EOF (valid parity) -> ndata = bits {0,5,36} set; exactly one ndata_valid pulse 4 edges after the EOF toggle; link_up=1; err_count=0.
- SOF, note 3, SOF, note 7, EOF -> ndata has only bit 7 set; one frame_err pulse; err_count=1.
- SOF, note 2, then no words for FRAME_TIMEOUT cycles -> frame_err pulse, FSM back in IDLE, ndata keeps its previous value, a later EOF is ignored.
- Code 40 inside a frame, then 300 errors -> err_count reads 1 after the first error and saturates at 255.
- No frames for STALE_CYCLES after a publish -> ndata=0, link_up=0, no ndata_valid pulse.
- With JA_PARITY_CHECK_EN: note 4 sent with bad parity inside a frame -> frame_err, bit 4 absent at EOF. Without the macro, the same stimulus -> bit 4 present and err_count=0.
